// File: rtl/fwd_scoreboard_if.sv
// fwd_scoreboard_if: ID-stage signals between the pipeline control and the
// operand-forwarding / load-use scoreboard.
interface fwd_scoreboard_if #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NUM_SRC = 2
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  logic                      id_valid;
  logic [31:0]               id_inst;
  logic                      advance;
  logic                      flush;
  logic [NUM_SRC*SELW-1:0]   fwd_sel;
  logic                      stall;
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;

  // Pipeline control side: presents the ID instruction, consumes selects/stall.
  modport master (
    output id_valid, id_inst, advance, flush,
    input  fwd_sel, stall, stall_cnt, fwd_cnt
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_inst, advance, flush,
    output fwd_sel, stall, stall_cnt, fwd_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks rd of the DEPTH instructions in flight past ID and
// produces per-source forwarding selects plus a load-use stall.
// Optional event counters are built only when FWD_STATS_EN is defined;
// otherwise stall_cnt/fwd_cnt read as zero.
module fwd_scoreboard #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fwd_scoreboard_if.slave    bus
);
  localparam int unsigned SELW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Tracked entries; index k is k+1 stages ahead of ID.
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][4:0]   rd_q,  rd_d;
  logic [DEPTH-1:0]        ld_q,  ld_d;

  logic [6:0]              opc_c;
  logic [4:0]              rd_c;
  logic [1:0][4:0]         rs_c;
  logic [1:0]              has_rs_c;
  logic                    has_rd_c;
  logic                    is_load_c;

  logic [NUM_SRC-1:0][DEPTH-1:0] hit_c;
  logic [NUM_SRC-1:0][SELW-1:0]  sel_c;
  logic                          stall_c;

  // Funct fields and the oldest load flag do not influence anything.
  logic unused_bits;
  assign unused_bits = ^{bus.id_inst[31:25], bus.id_inst[14:12], ld_q[DEPTH-1]};

  // Decode of the instruction sitting in ID.
  always_comb begin
    opc_c       = bus.id_inst[6:0];
    rd_c        = bus.id_inst[11:7];
    rs_c[0]     = bus.id_inst[19:15];
    rs_c[1]     = bus.id_inst[24:20];
    has_rd_c    = !(opc_c == OPC_BRANCH || opc_c == OPC_STORE) && (rd_c != 5'd0);
    is_load_c   = (opc_c == OPC_LOAD);
    has_rs_c[0] = !(opc_c == OPC_LUI || opc_c == OPC_AUIPC || opc_c == OPC_JAL);
    has_rs_c[1] = (opc_c == OPC_OP) || (opc_c == OPC_STORE) || (opc_c == OPC_BRANCH);
  end

  // Per-source, per-entry rd match.
  always_comb begin
    hit_c = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int k = 0; k < DEPTH; k++) begin
        hit_c[s][k] = vld_q[k] && (rd_q[k] == rs_c[s]) && (rs_c[s] != 5'd0) && has_rs_c[s];
      end
    end
  end

  // Load-use stall and youngest-hit-wins select; selects are zeroed while stalled.
  always_comb begin
    stall_c = 1'b0;
    sel_c   = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (hit_c[s][0] && ld_q[0]) stall_c = 1'b1;
    end
    stall_c = stall_c && bus.id_valid;
    if (!stall_c) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (hit_c[s][k] && (sel_c[s] == '0)) sel_c[s] = SELW'(k + 1);
        end
      end
    end
  end

  assign bus.fwd_sel = sel_c;
  assign bus.stall   = stall_c;

  // Shift the tracker on advance; a stalled or flushed ID slot enters as a bubble.
  always_comb begin
    vld_d = vld_q;
    rd_d  = rd_q;
    ld_d  = ld_q;
    if (bus.advance) begin
      for (int k = 1; k < DEPTH; k++) begin
        vld_d[k] = vld_q[k-1];
        rd_d[k]  = rd_q[k-1];
        ld_d[k]  = ld_q[k-1];
      end
      vld_d[0] = bus.id_valid && has_rd_c && !stall_c && !bus.flush;
      rd_d[0]  = rd_c;
      ld_d[0]  = is_load_c;
    end
  end

  // Tracker state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rd_q  <= '0;
      ld_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      ld_q  <= ld_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fwd_cnt_q,   fwd_cnt_d;

  // Saturating stall / forward event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (bus.advance && stall_c && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (bus.advance && !stall_c && (|sel_c) && (fwd_cnt_q != 32'hFFFF_FFFF))
      fwd_cnt_d = fwd_cnt_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.fwd_cnt   = fwd_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.fwd_cnt   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed vectors for the forwarding/load-use scoreboard
// (DEPTH=2, NUM_SRC=2). fwd_sel[1:0] is the rs1 field, fwd_sel[3:2] the rs2 field.
module tb_fwd_scoreboard;
  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;

  fwd_scoreboard_if #(.DEPTH(2), .NUM_SRC(2)) bus ();

  fwd_scoreboard #(.DEPTH(2), .NUM_SRC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FWD_STATS_EN
  localparam logic [31:0] EXP_STALL_CNT = 32'd1;
  localparam logic [31:0] EXP_FWD_CNT   = 32'd3;
`else
  localparam logic [31:0] EXP_STALL_CNT = 32'd0;
  localparam logic [31:0] EXP_FWD_CNT   = 32'd0;
`endif

  function automatic logic [31:0] op_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] op_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] op_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] op_sw(input logic [4:0] rs2, input logic [4:0] rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] op_lui(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] op_auipc(input logic [4:0] rd, input logic [19:0] imm);
    return {imm, rd, 7'b0010111};
  endfunction

  // Present one ID slot at the negedge; outputs settle by the #1.
  task automatic put(input logic v, input logic [31:0] inst, input logic adv, input logic fl);
    @(negedge clk);
    bus.id_valid = v;
    bus.id_inst  = inst;
    bus.advance  = adv;
    bus.flush    = fl;
    #1;
  endtask

  task automatic drain();
    repeat (2) put(1'b0, NOP, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL reset_sel: got %h want 0", bus.fwd_sel); end
    vecs++;
    if (bus.stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
    vecs++;
    put(1'b1, op_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    put(1'b1, op_add(5'd6, 5'd1, 5'd2), 1'b1, 1'b0);
    put(1'b1, op_add(5'd7, 5'd5, 5'd6), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0110) begin errs++; $display("FAIL prereset_sel: got %h want 6", bus.fwd_sel); end
    vecs++;
    #2 rst_n = 1'b0;
    #1;
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL async_reset_sel: got %h want 0", bus.fwd_sel); end
    vecs++;
    if (bus.stall !== 1'b0) begin errs++; $display("FAIL async_reset_stall: got %b want 0", bus.stall); end
    vecs++;
    bus.id_valid = 1'b0;
    bus.id_inst  = NOP;
    @(negedge clk);
    rst_n = 1'b1;
    put(1'b1, op_add(5'd7, 5'd5, 5'd6), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL post_reset_sel: got %h want 0", bus.fwd_sel); end
    vecs++;
    if (bus.stall_cnt !== 32'd0 || bus.fwd_cnt !== 32'd0) begin
      errs++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.fwd_cnt);
    end
    vecs++;
    drain();
  endtask

  task automatic test_forward();
    put(1'b1, op_add(5'd5, 5'd1, 5'd2), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL fwd_first: got %h want 0", bus.fwd_sel); end
    vecs++;
    put(1'b1, op_add(5'd6, 5'd5, 5'd5), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0101) begin errs++; $display("FAIL fwd_entry0: got %h want 5", bus.fwd_sel); end
    vecs++;
    put(1'b1, op_add(5'd12, 5'd5, 5'd0), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0010) begin errs++; $display("FAIL fwd_entry1: got %h want 2", bus.fwd_sel); end
    vecs++;
    drain();
  endtask

  task automatic test_load_use();
    put(1'b1, op_lw(5'd7, 5'd1), 1'b1, 1'b0);
    put(1'b1, op_add(5'd8, 5'd7, 5'd0), 1'b1, 1'b0);
    if (bus.stall !== 1'b1) begin errs++; $display("FAIL lu_stall: got %b want 1", bus.stall); end
    vecs++;
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL lu_sel_forced: got %h want 0", bus.fwd_sel); end
    vecs++;
    put(1'b1, op_add(5'd8, 5'd7, 5'd0), 1'b1, 1'b0);
    if (bus.stall !== 1'b0) begin errs++; $display("FAIL lu_release: got %b want 0", bus.stall); end
    vecs++;
    if (bus.fwd_sel !== 4'b0010) begin errs++; $display("FAIL lu_sel_after: got %h want 2", bus.fwd_sel); end
    vecs++;
    drain();
    if (bus.stall_cnt !== EXP_STALL_CNT) begin errs++; $display("FAIL stall_cnt: got %0d want %0d", bus.stall_cnt, EXP_STALL_CNT); end
    vecs++;
    if (bus.fwd_cnt !== EXP_FWD_CNT) begin errs++; $display("FAIL fwd_cnt: got %0d want %0d", bus.fwd_cnt, EXP_FWD_CNT); end
    vecs++;
  endtask

  task automatic test_x0_no_rd();
    put(1'b1, op_addi(5'd0, 5'd3, 12'd1), 1'b1, 1'b0);
    put(1'b1, op_sw(5'd3, 5'd4), 1'b1, 1'b0);
    put(1'b1, op_add(5'd9, 5'd0, 5'd3), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL x0_nord_sel: got %h want 0", bus.fwd_sel); end
    vecs++;
    if (bus.stall !== 1'b0) begin errs++; $display("FAIL x0_nord_stall: got %b want 0", bus.stall); end
    vecs++;
    drain();
  endtask

  task automatic test_youngest();
    put(1'b1, op_addi(5'd4, 5'd1, 12'd1), 1'b1, 1'b0);
    put(1'b1, op_addi(5'd4, 5'd1, 12'd2), 1'b1, 1'b0);
    put(1'b1, op_add(5'd10, 5'd4, 5'd4), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0101) begin errs++; $display("FAIL youngest: got %h want 5", bus.fwd_sel); end
    vecs++;
    drain();
    put(1'b1, op_lui(5'd4, 20'h12345), 1'b1, 1'b0);
    put(1'b1, op_auipc(5'd13, 20'h00020), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL auipc_no_rs1: got %h want 0", bus.fwd_sel); end
    vecs++;
    put(1'b1, op_addi(5'd14, 5'd4, 12'd0), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0010) begin errs++; $display("FAIL lui_tracked: got %h want 2", bus.fwd_sel); end
    vecs++;
    drain();
  endtask

  task automatic test_freeze_flush();
    put(1'b1, op_add(5'd11, 5'd1, 5'd2), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      put(1'b1, op_add(5'd15, 5'd11, 5'd0), 1'b0, 1'b0);
      if (bus.fwd_sel !== 4'b0001) begin errs++; $display("FAIL freeze_%0d: got %h want 1", i, bus.fwd_sel); end
      vecs++;
    end
    put(1'b1, op_add(5'd15, 5'd11, 5'd0), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0001) begin errs++; $display("FAIL freeze_resume: got %h want 1", bus.fwd_sel); end
    vecs++;
    put(1'b1, op_add(5'd16, 5'd11, 5'd0), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0010) begin errs++; $display("FAIL freeze_held: got %h want 2", bus.fwd_sel); end
    vecs++;
    drain();
    put(1'b1, op_add(5'd11, 5'd1, 5'd2), 1'b1, 1'b1);
    put(1'b1, op_add(5'd17, 5'd11, 5'd11), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b0000) begin errs++; $display("FAIL flush_kill: got %h want 0", bus.fwd_sel); end
    vecs++;
    drain();
    put(1'b1, op_lw(5'd7, 5'd1), 1'b1, 1'b0);
    put(1'b1, op_add(5'd8, 5'd7, 5'd0), 1'b1, 1'b1);
    if (bus.stall !== 1'b1) begin errs++; $display("FAIL flush_stall_rep: got %b want 1", bus.stall); end
    vecs++;
    put(1'b1, op_add(5'd18, 5'd8, 5'd7), 1'b1, 1'b0);
    if (bus.fwd_sel !== 4'b1000 || bus.stall !== 1'b0) begin
      errs++; $display("FAIL flush_stall_bubble: got sel %h stall %b want 8/0", bus.fwd_sel, bus.stall);
    end
    vecs++;
    drain();
  endtask

  initial begin
    vecs         = 0;
    errs         = 0;
    rst_n        = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_inst  = NOP;
    bus.advance  = 1'b1;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    test_reset();
    test_forward();
    test_load_use();
    test_x0_no_rd();
    test_youngest();
    test_freeze_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
